// File: rtl/conv_cal.sv
// 5x5 binary-window convolution over a 28x28 one-bit image, streaming a 24x24 feature map.
// Define CONV_RELU_EN to clamp negative results to zero in the output register.
module conv_cal #(
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 16
) (
  input  logic                      sclk,
  input  logic                      s_rst_n,
  input  logic                      cal_start,
  input  logic [4:0]                col_data,
  output logic [4:0]                data_rd_addr,
  output logic [4:0]                conv_row_cnt,
  input  logic [25*WEIGHT_W-1:0]    kernel_w,
  input  logic signed [ACC_W-1:0]   bias,
  output logic signed [ACC_W-1:0]   conv_data,
  output logic                      conv_data_vld,
  output logic [4:0]                conv_col_out,
  output logic [4:0]                conv_row_out,
  output logic                      busy,
  output logic                      conv_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] NEXT  = 2'd3;

  localparam logic [4:0] LAST_COL = 5'd27;
  localparam logic [4:0] LAST_ROW = 5'd23;
  localparam logic [4:0] LAST_OUT = 5'd23;

  logic [1:0]  state;
  logic [1:0]  drain_cnt;

  logic        rd_vld_d1;
  logic [4:0]  addr_d1;
  logic [4:0]  row_d1;

  // window column c occupies win[c*5 +: 5]; column 4 is the newest, bit 0 the top row
  logic [24:0] win;
  logic        win_vld;
  logic [4:0]  col_d2;
  logic [4:0]  row_d2;

  logic signed [ACC_W-1:0] sum;
  logic [WEIGHT_W-1:0]     w;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state        <= IDLE;
      drain_cnt    <= 2'd0;
      data_rd_addr <= 5'd0;
      conv_row_cnt <= 5'd0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cal_start) begin
            state        <= RD;
            data_rd_addr <= 5'd0;
            conv_row_cnt <= 5'd0;
            busy         <= 1'b1;
          end
        end
        RD: begin
          if (data_rd_addr == LAST_COL) begin
            state     <= DRAIN;
            drain_cnt <= 2'd0;
          end else begin
            data_rd_addr <= data_rd_addr + 5'd1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd2) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (conv_row_cnt == LAST_ROW) begin
            conv_row_cnt <= 5'd0;
            state        <= IDLE;
            busy         <= 1'b0;
          end else begin
            conv_row_cnt <= conv_row_cnt + 5'd1;
            data_rd_addr <= 5'd0;
            state        <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address issue is tracked alongside the RAM latency so col_data lines up with its column.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rd_vld_d1 <= 1'b0;
      addr_d1   <= 5'd0;
      row_d1    <= 5'd0;
      win       <= 25'd0;
      win_vld   <= 1'b0;
      col_d2    <= 5'd0;
      row_d2    <= 5'd0;
    end else begin
      rd_vld_d1 <= (state == RD);
      addr_d1   <= data_rd_addr;
      row_d1    <= conv_row_cnt;
      win       <= {col_data, win[24:5]};
      win_vld   <= rd_vld_d1 && (addr_d1 >= 5'd4);
      col_d2    <= addr_d1 - 5'd4;
      row_d2    <= row_d1;
    end
  end

  always_comb begin
    sum = bias;
    w   = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w = kernel_w[(r*5+c)*WEIGHT_W +: WEIGHT_W];
        if (win[c*5+r]) begin
          sum = sum + $signed({{(ACC_W-WEIGHT_W){w[WEIGHT_W-1]}}, w});
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      conv_data     <= '0;
      conv_data_vld <= 1'b0;
      conv_col_out  <= 5'd0;
      conv_row_out  <= 5'd0;
      conv_done     <= 1'b0;
    end else begin
      conv_data_vld <= win_vld;
      conv_done     <= conv_data_vld && (conv_col_out == LAST_OUT) && (conv_row_out == LAST_OUT);
      if (win_vld) begin
`ifdef CONV_RELU_EN
        conv_data <= sum[ACC_W-1] ? '0 : sum;
`else
        conv_data <= sum;
`endif
        conv_col_out <= col_d2;
        conv_row_out <= row_d2;
      end
    end
  end

endmodule

// File: tb/tb_conv_cal.sv
// Directed bench for conv_cal: RAM model, raster-order strobe checker and protocol timing checks.
module tb_conv_cal;

  localparam int WEIGHT_W = 8;
  localparam int ACC_W    = 16;

  logic                    sclk;
  logic                    s_rst_n;
  logic                    cal_start;
  logic [4:0]              col_data;
  logic [4:0]              data_rd_addr;
  logic [4:0]              conv_row_cnt;
  logic [25*WEIGHT_W-1:0]  kernel_w;
  logic signed [ACC_W-1:0] bias;
  logic signed [ACC_W-1:0] conv_data;
  logic                    conv_data_vld;
  logic [4:0]              conv_col_out;
  logic [4:0]              conv_row_out;
  logic                    busy;
  logic                    conv_done;

  conv_cal #(.WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) dut (
    .sclk          (sclk),
    .s_rst_n       (s_rst_n),
    .cal_start     (cal_start),
    .col_data      (col_data),
    .data_rd_addr  (data_rd_addr),
    .conv_row_cnt  (conv_row_cnt),
    .kernel_w      (kernel_w),
    .bias          (bias),
    .conv_data     (conv_data),
    .conv_data_vld (conv_data_vld),
    .conv_col_out  (conv_col_out),
    .conv_row_out  (conv_row_out),
    .busy          (busy),
    .conv_done     (conv_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int strobeCnt = 0;
  bit frameActive = 0;
  bit doneSeen = 0;

  logic img [28][28];
  int   wt [25];
  int   expAll;
  int   nHot;
  int   hotR [3];
  int   hotC [3];
  int   hotV [3];

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  // image RAM with one cycle of read latency
  always @(posedge sclk) begin
    for (int b = 0; b < 5; b++) begin
      col_data[b] <= img[int'(conv_row_cnt) + b][int'(data_rd_addr)];
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int reluExp(input int v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int expectedAt(input int r, input int c);
    int v;
    v = expAll;
    for (int h = 0; h < nHot; h++) begin
      if (hotR[h] == r && hotC[h] == c) v = hotV[h];
    end
    return reluExp(v);
  endfunction

  always @(negedge sclk) begin
    int k;
    int p;
    if (frameActive) begin
      k = cyc - startCyc;
      if (k >= 1 && k <= 768) begin
        p = (k - 1) % 32;
        checkOutput("rd_addr", int'(data_rd_addr), (p < 28) ? p : 27);
        checkOutput("row_cnt", int'(conv_row_cnt), (k - 1) / 32);
        checkOutput("busy_frame", int'(busy), 1);
      end
      if (conv_data_vld) begin
        checkOutput("row_out", int'(conv_row_out), strobeCnt / 24);
        checkOutput("col_out", int'(conv_col_out), strobeCnt % 24);
        checkOutput("conv_data", int'(conv_data), expectedAt(strobeCnt / 24, strobeCnt % 24));
        strobeCnt++;
      end
      if (conv_done) begin
        checkOutput("done_cycle", k, 768);
        doneSeen = 1;
      end
    end
  end

  task automatic clearImage(input logic v);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        img[r][c] = v;
  endtask

  task automatic setWeights(input int v);
    for (int i = 0; i < 25; i++) wt[i] = v;
  endtask

  task automatic loadWeights();
    for (int i = 0; i < 25; i++) kernel_w[i*WEIGHT_W +: WEIGHT_W] = 8'(wt[i]);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"}, int'(data_rd_addr), 0);
    checkOutput({tag, "_rowcnt"}, int'(conv_row_cnt), 0);
    checkOutput({tag, "_data"}, int'(conv_data), 0);
    checkOutput({tag, "_vld"}, int'(conv_data_vld), 0);
    checkOutput({tag, "_colout"}, int'(conv_col_out), 0);
    checkOutput({tag, "_rowout"}, int'(conv_row_out), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(conv_done), 0);
  endtask

  task automatic applyStimulus();
    @(negedge sclk);
    strobeCnt   = 0;
    doneSeen    = 0;
    startCyc    = cyc;
    frameActive = 1;
    cal_start   = 1'b1;
  endtask

  task automatic runFrame(input int dupAt, input int abortAt);
    bit aborted;
    int k;
    aborted = 0;
    loadWeights();
    applyStimulus();
    for (int n = 0; n < 900 && !doneSeen && !aborted; n++) begin
      @(negedge sclk);
      k = cyc - startCyc;
      cal_start = (dupAt > 0 && k == dupAt) ? 1'b1 : 1'b0;
      if (abortAt > 0 && k == abortAt) begin
        frameActive = 0;
        s_rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        @(negedge sclk);
        checkAllZero("abort_hold");
        s_rst_n = 1'b1;
        aborted = 1;
      end
    end
    cal_start = 1'b0;
    if (!aborted) begin
      checkOutput("done_seen", int'(doneSeen), 1);
      repeat (2) @(negedge sclk);
      checkOutput("strobes", strobeCnt, 576);
      checkOutput("busy_after", int'(busy), 0);
      checkOutput("vld_after", int'(conv_data_vld), 0);
      checkOutput("done_after", int'(conv_done), 0);
    end
    frameActive = 0;
    repeat (3) @(negedge sclk);
  endtask

  initial begin
    s_rst_n   = 1'b0;
    cal_start = 1'b0;
    bias      = '0;
    kernel_w  = '0;
    nHot      = 0;
    expAll    = 0;
    clearImage(1'b0);
    setWeights(0);
    repeat (3) @(negedge sclk);
    checkAllZero("reset");
    s_rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    $display("[TB] all-zero image, bias 5, duplicate start at cycle 100");
    for (int i = 0; i < 25; i++) wt[i] = i * 3 - 20;
    bias = 16'sd5; expAll = 5; nHot = 0;
    runFrame(100, 0);

    $display("[TB] all-one image, weights 1");
    clearImage(1'b1); setWeights(1);
    bias = 16'sd0; expAll = 25;
    runFrame(0, 0);

    $display("[TB] all-one image, weights -128");
    setWeights(-128);
    expAll = -3200;
    runFrame(0, 0);

    $display("[TB] single pixel at (10,10), center weight 3");
    clearImage(1'b0); setWeights(0);
    img[10][10] = 1'b1; wt[2*5+2] = 3;
    expAll = 0; nHot = 1;
    hotR[0] = 8; hotC[0] = 8; hotV[0] = 3;
    runFrame(0, 0);

    $display("[TB] asymmetric kernel and corner pixel");
    clearImage(1'b0); setWeights(0);
    img[5][12] = 1'b1; img[27][27] = 1'b1;
    wt[1*5+3] = -7; wt[4*5+4] = 100;
    bias = 16'sd2; expAll = 2; nHot = 3;
    hotR[0] = 4;  hotC[0] = 9;  hotV[0] = -5;
    hotR[1] = 1;  hotC[1] = 8;  hotV[1] = 102;
    hotR[2] = 23; hotC[2] = 23; hotV[2] = 102;
    runFrame(0, 0);

    $display("[TB] accumulator wrap: bias 32767 plus 25");
    clearImage(1'b1); setWeights(1);
    bias = 16'sd32767; expAll = -32744; nHot = 0;
    runFrame(0, 0);

    $display("[TB] reset at cycle 300, then clean frame with bias -10");
    clearImage(1'b0); setWeights(7);
    bias = 16'sd5; expAll = 5;
    runFrame(0, 300);
    bias = -16'sd10; expAll = -10;
    runFrame(0, 0);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_cal.md
Name: conv_cal

Overview:
- Downstream consumer of the downsampled binary image RAM.
- On cal_start, sweeps a 5x5 window over the 28x28 one-bit image by driving a column read address and an output-row index.
- Assembles each 5x5 window from 5-bit column slices and computes a bias plus the sum of signed kernel weights at set pixels.
- Emits the 24x24 feature map in raster order with a valid strobe.

Parameters:
- WEIGHT_W, 8, signed width of each kernel weight.
- ACC_W, 16, signed width of bias and result; must be at least WEIGHT_W+5.

Ports:
- sclk  in  1  system clock.
- s_rst_n  in  1  asynchronous active-low reset.
- cal_start  in  1  one-cycle pulse: image complete, start frame.
- col_data  in  5  image rows conv_row_cnt..conv_row_cnt+4 of the column at last cycle's data_rd_addr; bit0 is the top row.
- data_rd_addr  out  5  column read address, registered.
- conv_row_cnt  out  5  current output row 0..23, registered.
- kernel_w  in  25*WEIGHT_W  weights; weight (r,c) at slice index r*5+c, r = window row, c = window column.
- bias  in  ACC_W  signed bias.
- conv_data  out  ACC_W  signed result.
- conv_data_vld  out  1  result strobe.
- conv_col_out  out  5  output column of conv_data.
- conv_row_out  out  5  output row of conv_data.
- busy  out  1  frame in progress.
- conv_done  out  1  one-cycle pulse after the last result.

Behaviour:
- Reset: all outputs and registers are 0; the FSM goes to IDLE.
- Reset mid-frame aborts the frame immediately; no conv_done is issued.
- States: IDLE, RD, DRAIN, NEXT.
- IDLE:
  - busy=0.
  - cal_start -> RD with data_rd_addr=0, conv_row_cnt=0, busy=1.
- RD:
  - data_rd_addr increments every cycle from 0 to 27.
  - At 27 -> DRAIN; data_rd_addr holds 27.
- DRAIN: 3 cycles, flushing the pipeline -> NEXT.
- NEXT: 1 cycle.
  - If conv_row_cnt==23: conv_row_cnt goes to 0 -> IDLE, busy=0.
  - Else: conv_row_cnt+1, data_rd_addr=0 -> RD.
- conv_row_cnt changes only in NEXT, so col_data is stable for a whole row sweep.
- Read pipeline: RAM has 1-cycle read latency.
  - Cycle t: address a.
  - Cycle t+1: col_data for column a; the 5x5 window shift register shifts it in at the end of t+1.
  - Cycle t+2: if a>=4, the window holds columns a-4..a; the sum is computed and registered.
  - Cycle t+3: conv_data_vld=1, conv_col_out=a-4, conv_row_out = row at issue.
- Latency from address to result is 3 cycles.
- Stale columns from the previous row are never used; they are gated by a>=4.
- Row period is 32 cycles; a frame is 768 cycles from cal_start to conv_done.
- Exactly 24 strobes per row and 576 per frame.
- Arithmetic:
  - Each term is the weight if its pixel is 1, else 0.
  - Terms are sign-extended to ACC_W, summed, and added to bias.
  - Addition wraps in two's complement.
- conv_done pulses in the cycle after the final strobe (row 23, column 23).
- cal_start while busy=1 is ignored, including in the final NEXT cycle.
- kernel_w and bias are sampled combinationally during compute and must be held stable while busy.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: a negative result is output as 0 while conv_data_vld stays asserted; non-negative results pass unchanged. Applied in the output register, so latency is unchanged.
- Undefined: the raw signed result is output.

Test Plan:
- All-zero image, bias=5, any weights, cal_start -> 576 strobes, all conv_data=5, raster order, conv_done 768 cycles after cal_start.
- All-one image, all weights=1, bias=0 -> every conv_data=25.
- All-one image, all weights=-128, bias=0 -> every conv_data=-3200 (0xF380).
- Single pixel at image (10,10), center weight (2,2)=3, other weights 0, bias=0:
  - conv_data=3 only at output (8,8).
  - All other 575 outputs are 0.
- Protocol:
  - data_rd_addr runs 0..27 per row.
  - conv_row_cnt is constant across each sweep and steps only after 4 idle cycles.
  - A second cal_start at cycle 100 is ignored (still 576 strobes).
  - Reset at cycle 300 zeroes all outputs; a following cal_start runs a full clean frame.
- With CONV_RELU_EN, all-zero image, bias=-10 -> all 576 outputs are 0. Without it, all outputs are -10.
